weight_fifo_ctrl: RTL and testbench

Parametrised successor to the weight-FIFO load controller. It sequences loading of one weight tile into a FIFO_WIDTH-lane weight FIFO, with a runtime row count and optional per-lane staggered (diagonal) enables for systolic-array skew. It adds a command handshake, abort, and a single-cycle completion pulse. It sits between the weight fetch unit and the weight FIFO lanes.

---
 rtl/weight_fifo_pkg.sv | 25 ++
 rtl/weight_fifo_lane_window.sv | 26 ++
 rtl/weight_fifo_ctrl.sv | 142 ++++++++++++++
 tb/tb_weight_fifo_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/weight_fifo_pkg.sv
// Shared types and width helpers for the weight-FIFO load controller, FIFO lanes and array.
package weight_fifo_pkg;

  localparam int unsigned DefFifoWidth = 16;
  localparam int unsigned DefDepth     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain
  } state_e;

  function automatic int unsigned rows_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // One spare bit so R + lanes - 2 never wraps.
  function automatic int unsigned cnt_width(input int unsigned depth, input int unsigned lanes);
    return $clog2(depth + lanes) + 1;
  endfunction

  localparam int unsigned DefRowsWidth = rows_width(DefDepth);
  localparam int unsigned DefCntWidth  = cnt_width(DefDepth, DefFifoWidth);

endpackage

// File: rtl/weight_fifo_lane_window.sv
// Per-lane enable window: lane is enabled for cnt in [lane, lane+rows) when staggered,
// otherwise for cnt < rows. Skew compare exists only with WEIGHT_FIFO_CTRL_STAGGER_EN.
module weight_fifo_lane_window #(
  parameter int unsigned CW = 6,
  parameter int unsigned RW = 5
) (
  input  logic [CW-1:0] lane,
  input  logic [CW-1:0] cnt,
  input  logic [RW-1:0] rows,
  input  logic          stagger,
  output logic          en
);

`ifdef WEIGHT_FIFO_CTRL_STAGGER_EN
  logic in_window;

  assign in_window = (cnt >= lane) && (cnt < lane + CW'(rows));
  assign en        = stagger ? in_window : (cnt < CW'(rows));
`else
  logic unused_window;

  assign unused_window = ^{lane, stagger};
  assign en            = cnt < CW'(rows);
`endif

endmodule

// File: rtl/weight_fifo_ctrl.sv
// Weight-tile load sequencer for a FIFO_WIDTH-lane weight FIFO with optional diagonal skew.
// Stagger mode and the DRAIN state are built only when WEIGHT_FIFO_CTRL_STAGGER_EN is defined.
module weight_fifo_ctrl
  import weight_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DefFifoWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [rows_width(DEPTH)-1:0]   rows,
  input  logic                           stagger_load,
  input  logic                           abort,
  output logic [FIFO_WIDTH-1:0]          fifo_en,
  output logic                           weight_write,
  output logic [$clog2(DEPTH)-1:0]       row_idx,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned RW = rows_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH, FIFO_WIDTH);
  localparam int unsigned IW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic            s_q, s_d;
  logic [CW-1:0]   last_c;
  logic [RW-1:0]   rows_clamped;

  logic [FIFO_WIDTH-1:0] lane_en;
  logic [FIFO_WIDTH-1:0] fifo_en_d;
  logic                  weight_write_d;
  logic [IW-1:0]         row_idx_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  err_d;

`ifndef WEIGHT_FIFO_CTRL_STAGGER_EN
  logic unused_stagger;
  assign unused_stagger = stagger_load;
`endif

  assign rows_clamped = (rows > RW'(DEPTH)) ? RW'(DEPTH) : rows;
  assign last_c       = s_q ? CW'(r_q) + CW'(FIFO_WIDTH - 2) : CW'(r_q) - CW'(1);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    s_d     = s_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (rows == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
            c_d     = '0;
            r_d     = rows_clamped;
`ifdef WEIGHT_FIFO_CTRL_STAGGER_EN
            s_d     = stagger_load;
`else
            s_d     = 1'b0;
`endif
          end
        end
      end
      StLoad, StDrain: begin
        if (c_q == last_c) begin
          state_d = StIdle;
          c_d     = '0;
          done_d  = 1'b1;
        end else begin
          c_d     = c_q + CW'(1);
          state_d = (c_d < CW'(r_q)) ? StLoad : StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d = StIdle;
      c_d     = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
    weight_fifo_lane_window #(
      .CW(CW),
      .RW(RW)
    ) u_window (
      .lane   (CW'(i)),
      .cnt    (c_d),
      .rows   (r_d),
      .stagger(s_d),
      .en     (lane_en[i])
    );
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    busy_d         = state_d != StIdle;
    weight_write_d = busy_d && (c_d < CW'(r_d));
    row_idx_d      = weight_write_d ? c_d[IW-1:0] : '0;
    fifo_en_d      = busy_d ? lane_en : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      c_q          <= '0;
      r_q          <= '0;
      s_q          <= 1'b0;
      fifo_en      <= '0;
      weight_write <= 1'b0;
      row_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      r_q          <= r_d;
      s_q          <= s_d;
      fifo_en      <= fifo_en_d;
      weight_write <= weight_write_d;
      row_idx      <= row_idx_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_weight_fifo_ctrl.sv
// Bench for weight_fifo_ctrl: directed tiles plus random commands against a per-command
// model that expands each accepted command into its expected cycle-by-cycle output list.
module tb_weight_fifo_ctrl;

  localparam int unsigned FW = 16;
  localparam int unsigned D  = 16;
`ifdef WEIGHT_FIFO_CTRL_STAGGER_EN
  localparam bit StaggerBuilt = 1'b1;
`else
  localparam bit StaggerBuilt = 1'b0;
`endif

  typedef struct packed {
    logic [FW-1:0] en;
    logic          ww;
    logic [3:0]    idx;
    logic          busy;
    logic          done;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    rows = '0;
  logic          stagger_load = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] fifo_en;
  logic          weight_write;
  logic [3:0]    row_idx;
  logic          busy;
  logic          done;
  logic          err;

  int   errors = 0;
  int   checks = 0;
  exp_t cur = '0;
  exp_t q[$];

  weight_fifo_ctrl #(
    .FIFO_WIDTH(FW),
    .DEPTH     (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rows        (rows),
    .stagger_load(stagger_load),
    .abort       (abort),
    .fifo_en     (fifo_en),
    .weight_write(weight_write),
    .row_idx     (row_idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    check("fifo_en", 32'(fifo_en), 32'(cur.en));
    check("weight_write", 32'(weight_write), 32'(cur.ww));
    check("row_idx", 32'(row_idx), 32'(cur.idx));
    check("busy", 32'(busy), 32'(cur.busy));
    check("done", 32'(done), 32'(cur.done));
    check("err", 32'(err), 32'(cur.err));
  endtask

  // Expand one accepted command into its run cycles followed by the done cycle.
  task automatic push_run(input logic [4:0] rw, input logic stg);
    int   r;
    int   len;
    bit   s;
    exp_t e;
    r   = (rw > D) ? D : int'(rw);
    s   = StaggerBuilt && stg;
    len = s ? r + FW - 1 : r;
    for (int t = 0; t < len; t++) begin
      e      = '0;
      e.busy = 1'b1;
      e.ww   = t < r;
      if (e.ww) e.idx = t[3:0];
      for (int i = 0; i < FW; i++) e.en[i] = s ? ((t >= i) && (t < i + r)) : 1'b1;
      q.push_back(e);
    end
    e      = '0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  // Applied at each rising edge using the inputs that were stable across it.
  task automatic model_edge();
    exp_t e;
    if (abort) begin
      q.delete();
    end else if (!cur.busy && start) begin
      if (rows == '0) begin
        e     = '0;
        e.err = 1'b1;
        q.push_back(e);
      end else begin
        push_run(rows, stagger_load);
      end
    end
    if (q.size() > 0) cur = q.pop_front();
    else cur = '0;
  endtask

  task automatic cycle(input logic st, input logic [4:0] rw, input logic sg, input logic ab);
    start        = st;
    rows         = rw;
    stagger_load = sg;
    abort        = ab;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_outputs();
    reset = 1'b1;
    idle(1);

    // Full tile, no skew
    cycle(1'b1, 5'd16, 1'b0, 1'b0);
    idle(18);

    // Short tile with skew
    cycle(1'b1, 5'd4, 1'b1, 1'b0);
    idle(21);

    // Reject, then clamp
    cycle(1'b1, 5'd0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 5'd20, 1'b0, 1'b0);
    idle(18);

    // Abort mid-run, then immediate restart
    cycle(1'b1, 5'd16, 1'b1, 1'b0);
    idle(5);
    cycle(1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 5'd3, 1'b0, 1'b0);
    idle(6);

    // Abort beats start in the same cycle, including a zero-row start
    cycle(1'b1, 5'd5, 1'b0, 1'b1);
    cycle(1'b1, 5'd0, 1'b0, 1'b1);
    idle(2);

    // Start held high: back-to-back tiles with one done cycle between
    for (int i = 0; i < 20; i++) cycle(1'b1, 5'd2, 1'(i % 2), 1'b0);
    idle(4);

    // Asynchronous reset mid-run (in DRAIN when skew is built)
    cycle(1'b1, StaggerBuilt ? 5'd4 : 5'd16, 1'b1, 1'b0);
    idle(8);
    #2 reset = 1'b0;
    #1;
    q.delete();
    cur = '0;
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    reset = 1'b1;
    idle(2);

    // Random commands
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, 5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0);
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
